// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: INIT/IF/ID/EX/MEM/WB/HALT with
// req/ready handshakes, datapath control decode, retire counter and timeout.
module multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [31:0]      I_INST,
  input  logic             I_IMEM_READY,
  input  logic             I_DMEM_READY,
  input  logic             I_BR_TAKEN,
  output logic             O_IMEM_REQ,
  output logic             O_IR_WE,
  output logic             O_PC_WE,
  output logic [1:0]       O_PC_SEL,
  output logic             O_ALU_SRC,
  output logic [3:0]       O_ALU_OP,
  output logic             O_DMEM_REQ,
  output logic             O_DMEM_WE,
  output logic             O_RF_WE,
  output logic [1:0]       O_WB_SEL,
  output logic [2:0]       O_STATE,
  output logic             O_HALT,
  output logic [1:0]       O_ERR,
  output logic [CNT_W-1:0] O_NUM_INST
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1101;
  localparam logic [3:0] ALU_BEQ   = 4'b1110;
  localparam logic [3:0] ALU_BLT   = 4'b1111;
  localparam logic [3:0] ALU_BLTU  = 4'b1100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [1:0]        err_q, err_d;
  logic              halt_q, halt_d;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_store;
  logic       timeout_hit;
  logic       retire;
  logic [3:0] alu_op_dec;
  logic       alu_src_dec;
  logic       unused_inst;

  assign opcode      = I_INST[6:0];
  assign rd          = I_INST[11:7];
  assign funct3      = I_INST[14:12];
  assign funct7_b5   = I_INST[30];
  assign is_store    = (opcode == OP_STORE);
  assign unused_inst = ^{I_INST[31], I_INST[29:15]};
  // TIMEOUT of zero disables the wait limit entirely
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));

  assign O_STATE    = state_q;
  assign O_HALT     = halt_q;
  assign O_ERR      = err_q;
  assign O_NUM_INST = num_q;

  // funct3 -> ALU op for register and immediate arithmetic
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ALU op and operand-B select decoded from the held instruction
  always_comb begin
    alu_op_dec  = ALU_ADD;
    alu_src_dec = 1'b1;
    case (opcode)
      OP_R: begin
        alu_op_dec  = arith_op(funct3, funct7_b5, 1'b1);
        alu_src_dec = 1'b0;
      end
      OP_IMM:  alu_op_dec = arith_op(funct3, funct7_b5, 1'b0);
      OP_LUI:  alu_op_dec = ALU_PASSB;
      OP_BRANCH: begin
        alu_src_dec = 1'b0;
        case (funct3[2:1])
          2'b10:   alu_op_dec = ALU_BLT;
          2'b11:   alu_op_dec = ALU_BLTU;
          default: alu_op_dec = ALU_BEQ;
        endcase
      end
      default: alu_op_dec = ALU_ADD;
    endcase
  end

  // State register plus retire counter, wait counter and sticky halt/error
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_INIT;
      wait_q  <= '0;
      num_q   <= '0;
      err_q   <= ERR_NONE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      num_q   <= num_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state and combinational datapath controls
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    halt_d     = halt_q;
    retire     = 1'b0;
    O_IMEM_REQ = 1'b0;
    O_IR_WE    = 1'b0;
    O_PC_WE    = 1'b0;
    O_PC_SEL   = 2'b00;
    O_ALU_SRC  = 1'b0;
    O_ALU_OP   = 4'b0000;
    O_DMEM_REQ = 1'b0;
    O_DMEM_WE  = 1'b0;
    O_RF_WE    = 1'b0;
    O_WB_SEL   = 2'b00;

    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        O_IMEM_REQ = 1'b1;
        if (I_IMEM_READY) begin
          O_IR_WE = 1'b1;
          state_d = S_ID;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
          halt_d  = 1'b1;
        end
      end
      S_ID: begin
        case (opcode)
          OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
          OP_JAL, OP_JALR, OP_BRANCH: state_d = S_EX;
          OP_SYSTEM: begin
            state_d = S_HALT;
            err_d   = ERR_NONE;
            halt_d  = 1'b1;
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
            halt_d  = 1'b1;
          end
        endcase
      end
      S_EX: begin
        O_ALU_OP  = alu_op_dec;
        O_ALU_SRC = alu_src_dec;
        if (opcode == OP_BRANCH) begin
          O_PC_WE  = 1'b1;
          O_PC_SEL = I_BR_TAKEN ? 2'b01 : 2'b00;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (opcode == OP_LOAD || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        O_DMEM_REQ = 1'b1;
        O_DMEM_WE  = is_store;
        if (I_DMEM_READY) begin
          if (is_store) begin
            O_PC_WE = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
          halt_d  = 1'b1;
        end
      end
      S_WB: begin
        O_RF_WE = (rd != 5'd0);
        O_PC_WE = 1'b1;
        if (opcode == OP_JAL) begin
          O_PC_SEL = 2'b01;
          O_WB_SEL = 2'b10;
        end else if (opcode == OP_JALR) begin
          O_PC_SEL = 2'b10;
          O_WB_SEL = 2'b10;
        end else if (opcode == OP_LOAD) begin
          O_WB_SEL = 2'b01;
        end
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: halt_d = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

  // Retire count wraps naturally; wait count restarts on every state change
  always_comb begin
    num_d  = retire ? num_q + CNT_W'(1) : num_q;
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_IF || state_q == S_MEM) && !timeout_hit &&
                 wait_q != WAIT_W'(TIMEOUT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

endmodule
